parity_stream_gen_chk: RTL

//  Streaming even/odd parity generator and checker for DATA_W-bit words.
//  - Per accepted word: generates the parity bit and checks a received parity bit.
//  - Each word carries its own mode bit: 0 = even, 1 = odd.
//  - Keeps saturating error and word counters, plus a sticky error flag.
//  - Sits between a word source and a sink on valid/ready handshakes.
//  - Registered successor of the 3-bit combinational parity gen/check block.

---
 rtl/parity_stream_gen_chk.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/parity_stream_gen_chk.sv
// Streaming even/odd parity generator and checker for DATA_W-bit words.
// One output register sits between a valid/ready source and sink, so the
// block passes one word per cycle with one cycle of latency. Each accepted
// word gets a generated parity bit and a check of its received parity bit.
// Saturating word/error counters and a sticky error flag track the stream.
module parity_stream_gen_chk #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_par,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_par,
    output logic              out_err,
    input  logic              clr_count,
    output logic [CNT_W-1:0]  err_count,
    output logic [CNT_W-1:0]  word_count,
    output logic              err_sticky
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // XOR-reduction of a data word: 1 when the word holds an odd number of ones.
    function automatic logic data_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    // Counter increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (c == CNT_MAX) begin
            r = c;
        end else begin
            r = c + CNT_ONE;
        end
        return r;
    endfunction

    logic              out_valid_r;
    logic [DATA_W-1:0] out_data_r;
    logic              out_par_r;
    logic              out_err_r;
    logic [CNT_W-1:0]  err_count_r;
    logic [CNT_W-1:0]  word_count_r;
    logic              err_sticky_r;

    logic              in_ready_s;
    logic              accept_s;
    logic              deliver_s;
    logic              gen_par_s;
    logic              err_s;
    logic [CNT_W-1:0]  err_count_nxt_s;
    logic [CNT_W-1:0]  word_count_nxt_s;
    logic              err_sticky_nxt_s;

    // Handshake decode and per-word parity generate/check.
    always_comb begin
        in_ready_s = (!out_valid_r) || out_ready;
        accept_s   = in_valid && in_ready_s;
        deliver_s  = out_valid_r && out_ready;
        gen_par_s  = data_parity(in_data) ^ in_mode;
        err_s      = gen_par_s ^ in_par;
    end

    // Next values for the statistics: clear wins over a simultaneous accept.
    always_comb begin
        err_count_nxt_s  = err_count_r;
        word_count_nxt_s = word_count_r;
        err_sticky_nxt_s = err_sticky_r;
        if (clr_count) begin
            err_count_nxt_s  = CNT_ZERO;
            word_count_nxt_s = CNT_ZERO;
            err_sticky_nxt_s = 1'b0;
        end else if (accept_s) begin
            word_count_nxt_s = sat_inc(word_count_r);
            if (err_s) begin
                err_count_nxt_s  = sat_inc(err_count_r);
                err_sticky_nxt_s = 1'b1;
            end else begin
                err_count_nxt_s  = err_count_r;
                err_sticky_nxt_s = err_sticky_r;
            end
        end else begin
            err_count_nxt_s  = err_count_r;
            word_count_nxt_s = word_count_r;
            err_sticky_nxt_s = err_sticky_r;
        end
    end

    // Occupancy of the output register: EMPTY (0) / FULL (1).
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
        end else if (accept_s) begin
            out_valid_r <= 1'b1;
        end else if (deliver_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Output word register: loads on accept, otherwise holds (stable under backpressure).
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r <= {DATA_W{1'b0}};
            out_par_r  <= 1'b0;
            out_err_r  <= 1'b0;
        end else if (accept_s) begin
            out_data_r <= in_data;
            out_par_r  <= gen_par_s;
            out_err_r  <= err_s;
        end else begin
            out_data_r <= out_data_r;
            out_par_r  <= out_par_r;
            out_err_r  <= out_err_r;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count_r  <= CNT_ZERO;
            word_count_r <= CNT_ZERO;
            err_sticky_r <= 1'b0;
        end else begin
            err_count_r  <= err_count_nxt_s;
            word_count_r <= word_count_nxt_s;
            err_sticky_r <= err_sticky_nxt_s;
        end
    end

    // Port hookup.
    always_comb begin
        in_ready   = in_ready_s;
        out_valid  = out_valid_r;
        out_data   = out_data_r;
        out_par    = out_par_r;
        out_err    = out_err_r;
        err_count  = err_count_r;
        word_count = word_count_r;
        err_sticky = err_sticky_r;
    end

endmodule
